// File: rtl/snake_sound_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : snake_sound_sequencer
// Description : Turns snake game events into timed tones for a single tone
//               generator. Rising edges of the event inputs become pending
//               requests, which are served one at a time by fixed priority.
//               Each request plays one note followed by a silent gap.
//               Game-over plays a three-note melody instead.
//               A mute toggle silences the block and discards requests.
// Revision    : 1.0 - initial release
// ============================================================================
module snake_sound_sequencer #(
    parameter int TICK_DIV   = 12000,
    parameter int NOTE_TICKS = 100,
    parameter int GAP_TICKS  = 10
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       goodColl,
    input  logic       badColl,
    input  logic       dirChange,
    input  logic       gameOver,
    input  logic       mutePressed,
    output logic       playSound,
    output logic [8:0] freq,
    output logic       busy,
    output logic       muted
);

    localparam int DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int NOTE_W  = (NOTE_TICKS > 1) ? $clog2(NOTE_TICKS) : 1;
    localparam int GAP_W   = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam int TCK_W   = (NOTE_W > GAP_W) ? NOTE_W : GAP_W;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
    localparam logic [TCK_W-1:0] NOTE_LAST = TCK_W'(NOTE_TICKS - 1);
    localparam logic [TCK_W-1:0] GAP_LAST  = TCK_W'(GAP_TICKS - 1);

    localparam logic [8:0] F_GOOD = 9'd440;
    localparam logic [8:0] F_BAD  = 9'd311;
    localparam logic [8:0] F_DIR  = 9'd262;
    localparam logic [8:0] F_MEL0 = 9'd392;
    localparam logic [8:0] F_MEL1 = 9'd330;
    localparam logic [8:0] F_MEL2 = 9'd262;

    // Request bit positions, highest priority in the top bit.
    localparam int B_GO   = 3;
    localparam int B_BAD  = 2;
    localparam int B_GOOD = 1;
    localparam int B_DIR  = 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         prev_q, pend_q, pend_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [TCK_W-1:0]   tick_q, tick_d;
    logic [1:0]         idx_q, idx_d;
    logic               mel_q, mel_d;
    logic               play_q, play_d;
    logic [8:0]         freq_q, freq_d;
    logic               busy_q, busy_d;
    logic               muted_q, muted_d;

    logic [3:0]         evt_w, edge_w;
    logic               tick_done_w;
    logic               do_grant_w;

    assign evt_w  = {gameOver, badColl, goodColl, dirChange};
    assign edge_w = evt_w & ~prev_q;

    assign tick_done_w = (div_q == DIV_LAST) &&
                         (tick_q == ((state_q == S_PLAY) ? NOTE_LAST : GAP_LAST));

    // Next-state, request bookkeeping and registered-output values.
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        div_d      = div_q;
        tick_d     = tick_q;
        idx_d      = idx_q;
        mel_d      = mel_q;
        play_d     = play_q;
        freq_d     = freq_q;
        muted_d    = muted_q;
        do_grant_w = 1'b0;

        // New edges latch as requests; a game-over while its melody is
        // already playing is absorbed into that melody.
        if (!muted_q) begin
            pend_d = pend_q | (edge_w & {~mel_q, 3'b111});
        end

        case (state_q)
            S_IDLE: begin
                if (|pend_q) begin
                    do_grant_w = 1'b1;
                end
            end
            S_PLAY: begin
                if (!mel_q && pend_q[B_GO]) begin
                    do_grant_w = 1'b1;
                end else if (tick_done_w) begin
                    state_d = S_GAP;
                    play_d  = 1'b0;
                    freq_d  = 9'd0;
                    div_d   = '0;
                    tick_d  = '0;
                end else if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    tick_d = tick_q + 1'b1;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_GAP: begin
                if (!mel_q && pend_q[B_GO]) begin
                    do_grant_w = 1'b1;
                end else if (tick_done_w) begin
                    if (mel_q && (idx_q < 2'd2)) begin
                        state_d = S_PLAY;
                        play_d  = 1'b1;
                        freq_d  = (idx_q == 2'd0) ? F_MEL1 : F_MEL2;
                        idx_d   = idx_q + 2'd1;
                        div_d   = '0;
                        tick_d  = '0;
                    end else if (|pend_q) begin
                        do_grant_w = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        mel_d   = 1'b0;
                        idx_d   = 2'd0;
                    end
                end else if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    tick_d = tick_q + 1'b1;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Start the highest-priority pending request and retire its flag.
        if (do_grant_w) begin
            state_d = S_PLAY;
            play_d  = 1'b1;
            div_d   = '0;
            tick_d  = '0;
            idx_d   = 2'd0;
            mel_d   = 1'b0;
            if (pend_q[B_GO]) begin
                freq_d       = F_MEL0;
                mel_d        = 1'b1;
                pend_d[B_GO] = 1'b0;
            end else if (pend_q[B_BAD]) begin
                freq_d        = F_BAD;
                pend_d[B_BAD] = 1'b0;
            end else if (pend_q[B_GOOD]) begin
                freq_d         = F_GOOD;
                pend_d[B_GOOD] = 1'b0;
            end else begin
                freq_d        = F_DIR;
                pend_d[B_DIR] = 1'b0;
            end
        end

        // Mute toggling overrides everything decided above in this cycle.
        if (mutePressed) begin
            muted_d = ~muted_q;
            if (!muted_q) begin
                pend_d  = 4'd0;
                state_d = S_IDLE;
                play_d  = 1'b0;
                freq_d  = 9'd0;
                mel_d   = 1'b0;
                idx_d   = 2'd0;
                div_d   = '0;
                tick_d  = '0;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= S_IDLE;
            prev_q  <= 4'd0;
            pend_q  <= 4'd0;
            div_q   <= '0;
            tick_q  <= '0;
            idx_q   <= 2'd0;
            mel_q   <= 1'b0;
            play_q  <= 1'b0;
            freq_q  <= 9'd0;
            busy_q  <= 1'b0;
            muted_q <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= evt_w;
            pend_q  <= pend_d;
            div_q   <= div_d;
            tick_q  <= tick_d;
            idx_q   <= idx_d;
            mel_q   <= mel_d;
            play_q  <= play_d;
            freq_q  <= freq_d;
            busy_q  <= busy_d;
            muted_q <= muted_d;
        end
    end

    assign playSound = play_q;
    assign freq      = freq_q;
    assign busy      = busy_q;
    assign muted     = muted_q;

endmodule
`default_nettype wire

// File: tb/tb_snake_sound_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_snake_sound_sequencer
// Description : Directed self-checking bench for snake_sound_sequencer with
//               TICK_DIV=4, NOTE_TICKS=3, GAP_TICKS=1 (note 12, gap 4 cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_snake_sound_sequencer;

    logic       clk = 1'b0;
    logic       nRst = 1'b0;
    logic       goodColl = 1'b0;
    logic       badColl = 1'b0;
    logic       dirChange = 1'b0;
    logic       gameOver = 1'b0;
    logic       mutePressed = 1'b0;
    logic       playSound;
    logic [8:0] freq;
    logic       busy;
    logic       muted;

    int tests = 0;
    int failed = 0;

    snake_sound_sequencer #(
        .TICK_DIV   (4),
        .NOTE_TICKS (3),
        .GAP_TICKS  (1)
    ) dut (
        .clk         (clk),
        .nRst        (nRst),
        .goodColl    (goodColl),
        .badColl     (badColl),
        .dirChange   (dirChange),
        .gameOver    (gameOver),
        .mutePressed (mutePressed),
        .playSound   (playSound),
        .freq        (freq),
        .busy        (busy),
        .muted       (muted)
    );

    // 10-unit clock period.
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Compare all four outputs at once against the expected values.
    task automatic chk(input string tag, input logic ep, input logic [8:0] ef,
                       input logic eb, input logic em);
        tests++;
        assert ({playSound, freq, busy, muted} === {ep, ef, eb, em})
        else begin
            failed++;
            $error("FAIL %s: observed play=%b freq=%0d busy=%b muted=%b, expected play=%b freq=%0d busy=%b muted=%b",
                   tag, playSound, freq, busy, muted, ep, ef, eb, em);
        end
    endtask

    initial begin
        // Reset held: outputs silent.
        #12;
        chk("reset_held", 1'b0, 9'd0, 1'b0, 1'b0);
        #10 nRst = 1'b1;
        step(2);
        chk("reset_idle", 1'b0, 9'd0, 1'b0, 1'b0);

        // Single good-collision event: sampled at edge 0.
        goodColl = 1'b1;
        step(1);
        chk("single_e0", 1'b0, 9'd0, 1'b0, 1'b0);
        step(1);
        chk("single_e1", 1'b1, 9'd440, 1'b1, 1'b0);
        step(11);
        chk("single_e12", 1'b1, 9'd440, 1'b1, 1'b0);
        step(1);
        chk("single_gap_e13", 1'b0, 9'd0, 1'b1, 1'b0);
        step(3);
        chk("single_gap_e16", 1'b0, 9'd0, 1'b1, 1'b0);
        step(1);
        chk("single_idle_e17", 1'b0, 9'd0, 1'b0, 1'b0);
        goodColl = 1'b0;
        step(2);

        // Priority: bad and dir rise together.
        badColl   = 1'b1;
        dirChange = 1'b1;
        step(2);
        chk("prio_bad_e1", 1'b1, 9'd311, 1'b1, 1'b0);
        step(12);
        chk("prio_gap_e13", 1'b0, 9'd0, 1'b1, 1'b0);
        step(4);
        chk("prio_dir_e17", 1'b1, 9'd262, 1'b1, 1'b0);
        step(12);
        chk("prio_gap_e29", 1'b0, 9'd0, 1'b1, 1'b0);
        step(4);
        chk("prio_idle_e33", 1'b0, 9'd0, 1'b0, 1'b0);
        badColl   = 1'b0;
        dirChange = 1'b0;
        step(2);

        // Preemption: game-over 5 cycles into a 440 note.
        goodColl = 1'b1;
        step(2);
        chk("pre_440_e1", 1'b1, 9'd440, 1'b1, 1'b0);
        step(4);
        gameOver = 1'b1;
        step(1);
        chk("pre_still440_e6", 1'b1, 9'd440, 1'b1, 1'b0);
        step(1);
        chk("pre_mel0_e7", 1'b1, 9'd392, 1'b1, 1'b0);
        step(12);
        chk("pre_gap0_e19", 1'b0, 9'd0, 1'b1, 1'b0);
        step(4);
        chk("pre_mel1_e23", 1'b1, 9'd330, 1'b1, 1'b0);
        // Re-trigger game-over mid-melody: must merge, not restart.
        gameOver = 1'b0;
        step(1);
        gameOver = 1'b1;
        step(1);
        chk("pre_merge_e25", 1'b1, 9'd330, 1'b1, 1'b0);
        step(10);
        chk("pre_gap1_e35", 1'b0, 9'd0, 1'b1, 1'b0);
        step(4);
        chk("pre_mel2_e39", 1'b1, 9'd262, 1'b1, 1'b0);
        step(12);
        chk("pre_gap2_e51", 1'b0, 9'd0, 1'b1, 1'b0);
        step(4);
        chk("pre_idle_e55", 1'b0, 9'd0, 1'b0, 1'b0);
        step(3);
        chk("pre_no_resume", 1'b0, 9'd0, 1'b0, 1'b0);
        goodColl = 1'b0;
        gameOver = 1'b0;
        step(2);

        // Mute during a 311 note, then an ignored good edge.
        badColl = 1'b1;
        step(2);
        chk("mute_311_e1", 1'b1, 9'd311, 1'b1, 1'b0);
        step(3);
        mutePressed = 1'b1;
        step(1);
        chk("mute_on", 1'b0, 9'd0, 1'b0, 1'b1);
        mutePressed = 1'b0;
        badColl     = 1'b0;
        goodColl    = 1'b1;
        step(2);
        chk("mute_ignore", 1'b0, 9'd0, 1'b0, 1'b1);
        mutePressed = 1'b1;
        step(1);
        chk("mute_off", 1'b0, 9'd0, 1'b0, 1'b0);
        mutePressed = 1'b0;
        step(3);
        chk("mute_no_sound", 1'b0, 9'd0, 1'b0, 1'b0);
        goodColl = 1'b0;
        step(2);

        // Merge: two bad edges during a 440 note give one 311 note.
        goodColl = 1'b1;
        step(2);
        chk("merge_440_e1", 1'b1, 9'd440, 1'b1, 1'b0);
        badColl = 1'b1;
        step(1);
        badColl = 1'b0;
        step(2);
        badColl = 1'b1;
        step(1);
        badColl = 1'b0;
        step(8);
        chk("merge_gap_e13", 1'b0, 9'd0, 1'b1, 1'b0);
        step(4);
        chk("merge_311_e17", 1'b1, 9'd311, 1'b1, 1'b0);
        step(12);
        chk("merge_gap_e29", 1'b0, 9'd0, 1'b1, 1'b0);
        step(4);
        chk("merge_idle_e33", 1'b0, 9'd0, 1'b0, 1'b0);
        goodColl = 1'b0;
        step(2);

        // Asynchronous reset mid-note.
        dirChange = 1'b1;
        step(2);
        chk("rst_dir_e1", 1'b1, 9'd262, 1'b1, 1'b0);
        step(3);
        #2 nRst = 1'b0;
        #1;
        chk("rst_async", 1'b0, 9'd0, 1'b0, 1'b0);
        dirChange = 1'b0;
        #2 nRst = 1'b1;
        step(2);
        chk("rst_after", 1'b0, 9'd0, 1'b0, 1'b0);
        step(4);
        chk("rst_stays_idle", 1'b0, 9'd0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
